// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multi-cycle arithmetic sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    COMMIT,
    EXC
  } muldiv_state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } muldiv_op_t;

  localparam int MULDIV_TIMEOUT_DEF = 64;

endpackage

// File: rtl/op_watchdog.sv
// Saturating cycle counter with synchronous clear; flags the last allowed
// wait cycle so the sequencer can abandon a unit that never finishes.
module op_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  // Count enabled cycles; stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != {CW{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multiplier/divider and owner of architectural HI/LO.
// Launches the selected unit, waits for its completion level, then commits
// the result, flags a divide-by-zero, or gives up on a watchdog timeout.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = MULDIV_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        busy,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        div_start,
  output logic        mult_start,
  input  logic        div_done,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_done,
  output logic        exc_div0,
  output logic        err_timeout
);

  muldiv_state_t state_reg;
  muldiv_op_t    op_reg;
  logic          wd_expired;
  logic          sel_done;
  logic [31:0]   sel_hi;
  logic [31:0]   sel_lo;

  // Watchdog is cleared while launching and only runs while waiting.
  op_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg == LAUNCH),
    .enable (state_reg == WAIT),
    .expired(wd_expired)
  );

  // Only the launched unit's flags and results are looked at.
  always_comb begin
    sel_done = (op_reg == OP_DIV) ? div_done : mult_done;
    sel_hi   = (op_reg == OP_DIV) ? div_hi   : mult_hi;
    sel_lo   = (op_reg == OP_DIV) ? div_lo   : mult_lo;
  end

  // Main sequencer; every output except busy/op_ready is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= OP_MULT;
      unit_a      <= '0;
      unit_b      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_start   <= 1'b0;
      mult_start  <= 1'b0;
      op_done     <= 1'b0;
      exc_div0    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      div_start  <= 1'b0;
      mult_start <= 1'b0;
      op_done    <= 1'b0;
      exc_div0   <= 1'b0;
      case (state_reg)
        IDLE: begin
          // MTHI/MTLO land now; a same-cycle op result overwrites them later.
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (op_valid) begin
            unit_a     <= op_a;
            unit_b     <= op_b;
            op_reg     <= op_is_div ? OP_DIV : OP_MULT;
            // Start is raised on entry so it is high during LAUNCH.
            div_start  <= op_is_div;
            mult_start <= ~op_is_div;
            state_reg  <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Flags are not sampled here: units clear stale done on start.
          state_reg <= WAIT;
        end
        WAIT: begin
          if ((op_reg == OP_DIV) && div_zero) begin
            exc_div0  <= 1'b1;
            state_reg <= EXC;
          end else if (sel_done) begin
            hi        <= sel_hi;
            lo        <= sel_lo;
            op_done   <= 1'b1;
            state_reg <= COMMIT;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        COMMIT:  state_reg <= IDLE;
        EXC:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign op_ready = (state_reg == IDLE);
  assign busy     = ~op_ready;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier/divider stubs.
module tb_muldiv_ctrl;

  localparam int TO = 40;
  localparam int K_COMMIT = 0;
  localparam int K_EXC    = 1;
  localparam int K_TMO    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_is_div;
  logic [31:0] op_a, op_b;
  logic        op_ready, busy;
  logic [31:0] unit_a, unit_b;
  logic        div_start, mult_start;
  logic        div_done, div_zero;
  logic [31:0] div_hi, div_lo;
  logic        mult_done;
  logic [31:0] mult_hi, mult_lo;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi, lo;
  logic        op_done, exc_div0, err_timeout;

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   start_pulses = 0;
  int   done_pulses = 0;

  // Stub controls
  logic stub_clr;
  logic hang;
  int   div_lat;
  int   dcnt, mcnt;
  logic signed [63:0] prod;
  logic [31:0] dq, dr;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .busy(busy), .unit_a(unit_a), .unit_b(unit_b),
    .div_start(div_start), .mult_start(mult_start),
    .div_done(div_done), .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .op_done(op_done), .exc_div0(exc_div0),
    .err_timeout(err_timeout)
  );

  // Behavioural arithmetic for the stubs (unit models, not the expectations).
  always_comb begin
    prod = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
    dq = '0;
    dr = '0;
    if (unit_b != 32'd0) begin
      dq = $signed(unit_a) / $signed(unit_b);
      dr = $signed(unit_a) % $signed(unit_b);
    end
  end

  // Divider stub: level flags cleared on start, done after div_lat cycles.
  always @(posedge clk) begin
    if (stub_clr) begin
      div_done <= 1'b0; div_zero <= 1'b0; div_hi <= '0; div_lo <= '0; dcnt <= 0;
    end else if (div_start) begin
      div_done <= 1'b0;
      div_zero <= 1'b0;
      dcnt     <= 0;
      if (!hang) begin
        if (unit_b == 32'd0) div_zero <= 1'b1;
        else dcnt <= div_lat;
      end
    end else if (dcnt == 1) begin
      div_done <= 1'b1; div_hi <= dr; div_lo <= dq; dcnt <= 0;
    end else if (dcnt > 1) begin
      dcnt <= dcnt - 1;
    end
  end

  // Multiplier stub: fixed three-cycle latency.
  always @(posedge clk) begin
    if (stub_clr) begin
      mult_done <= 1'b0; mult_hi <= '0; mult_lo <= '0; mcnt <= 0;
    end else if (mult_start) begin
      mult_done <= 1'b0; mcnt <= 3;
    end else if (mcnt == 1) begin
      mult_done <= 1'b1; mult_hi <= prod[63:32]; mult_lo <= prod[31:0]; mcnt <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.kind = kind; e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an outcome.
  initial begin
    logic to_prev;
    int   kind;
    exp_t e;
    to_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start || mult_start) start_pulses++;
      if (op_done) done_pulses++;
      if (!reset) begin
        kind = -1;
        if (op_done) kind = K_COMMIT;
        else if (exc_div0) kind = K_EXC;
        else if (err_timeout && !to_prev) kind = K_TMO;
        if (kind >= 0) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
          end else begin
            e = sb.pop_front();
            check("evt_kind", 32'(kind), 32'(e.kind));
            check("evt_hi", hi, e.hi);
            check("evt_lo", lo, e.lo);
          end
        end
      end
      to_prev = err_timeout;
    end
  end

  // Present a request for one cycle; returns at mid-cycle 1 (LAUNCH).
  task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: op_ready=%0b after %0d cycles, required 1", name, op_ready, n);
    end
  endtask

  initial begin
    int sp;
    reset = 1'b1; stub_clr = 1'b1; hang = 1'b0; div_lat = 32;
    op_valid = 1'b0; op_is_div = 1'b0; op_a = '0; op_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; stub_clr = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_unit_a", unit_a, 32'h0);

    // DIV 100/7 -> remainder 2, quotient 14
    sp = start_pulses;
    expect_evt(K_COMMIT, 32'd2, 32'd14);
    issue(1'b1, 32'd100, 32'd7);
    check("div1_start_c1", 32'(div_start), 32'd1);
    check("div1_busy_c1", 32'(busy), 32'd1);
    wait_idle("div1");
    check("div1_starts", 32'(start_pulses - sp), 32'd1);
    check("div1_exc", 32'(exc_div0), 32'd0);

    // DIV -7/2 -> quotient -3, remainder -1
    expect_evt(K_COMMIT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div2");

    // MULT 0x10000*0x10000 with stale div_done still high
    check("mult_stale_divdone", 32'(div_done), 32'd1);
    expect_evt(K_COMMIT, 32'd1, 32'd0);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    check("mult_start_c1", 32'(mult_start), 32'd1);
    wait_idle("mult1");

    // Preload HI/LO, then DIV 5/0
    wr_hi = 1'b1; wr_data = 32'hAAAA;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5555;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mthi", hi, 32'hAAAA);
    check("mtlo", lo, 32'h5555);
    expect_evt(K_EXC, 32'hAAAA, 32'h5555);
    issue(1'b1, 32'd5, 32'd0);
    @(negedge clk);
    check("dz_exc_c2", 32'(exc_div0), 32'd0);
    @(negedge clk);
    check("dz_exc_c3", 32'(exc_div0), 32'd1);
    check("dz_ready_c3", 32'(op_ready), 32'd0);
    @(negedge clk);
    check("dz_ready_c4", 32'(op_ready), 32'd1);
    check("dz_exc_c4", 32'(exc_div0), 32'd0);

    // Busy filtering: op_valid and wr_hi during WAIT are ignored
    sp = start_pulses;
    expect_evt(K_COMMIT, 32'd2, 32'd14);
    issue(1'b1, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'd9; op_b = 32'd0;
    wr_hi = 1'b1; wr_data = 32'hDEAD;
    @(negedge clk);
    op_valid = 1'b0; wr_hi = 1'b0;
    check("busy_hi_held", hi, 32'hAAAA);
    check("busy_unit_b", unit_b, 32'd7);
    wait_idle("busy");
    check("busy_starts", 32'(start_pulses - sp), 32'd1);

    // Watchdog: divider never answers
    hang = 1'b1;
    expect_evt(K_TMO, 32'd2, 32'd14);
    issue(1'b1, 32'd9, 32'd3);
    repeat (TO) @(negedge clk);
    check("wd_err_c41", 32'(err_timeout), 32'd0);
    check("wd_busy_c41", 32'(busy), 32'd1);
    @(negedge clk);
    check("wd_err_c42", 32'(err_timeout), 32'd1);
    check("wd_ready_c42", 32'(op_ready), 32'd1);
    hang = 1'b0;

    // Same-cycle MTLO with MULT 3*4: result overwrites, err stays sticky
    wr_lo = 1'b1; wr_data = 32'h77;
    expect_evt(K_COMMIT, 32'd0, 32'd12);
    issue(1'b0, 32'd3, 32'd4);
    wr_lo = 1'b0;
    check("same_cycle_mtlo", lo, 32'h77);
    wait_idle("mult2");
    check("wd_sticky", 32'(err_timeout), 32'd1);

    // Reset mid-WAIT discards the op
    issue(1'b1, 32'd50, 32'd5);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sp = done_pulses;
    check("mrst_hi", hi, 32'h0);
    check("mrst_lo", lo, 32'h0);
    check("mrst_ready", 32'(op_ready), 32'd1);
    check("mrst_err", 32'(err_timeout), 32'd0);
    repeat (40) @(negedge clk);
    check("mrst_divdone_seen", 32'(div_done), 32'd1);
    check("mrst_no_done", 32'(done_pulses - sp), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
